seq_ctrl_cond: RTL and testbench

- Upstream conditioner for the five-state output sequencer.
- Takes three raw, asynchronous, active-low push-buttons and produces clean, registered restart, pause and goto_third controls.
- Per button: synchronises, debounces, detects presses, latches pause as a toggle, and holds a goto request pending until the sequencer reports terminal.
- One instance per sequencer, clocked on the sequencer's clock.

---
 rtl/seq_ctrl_cond.sv | 116 +++++++++++
 tb/tb_seq_ctrl_cond.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_ctrl_cond.sv
`default_nettype none
// ============================================================================
// Module   : seq_ctrl_cond
// Brief    : Push-button conditioner for the five-state output sequencer.
//            Synchronises and debounces three active-low buttons and turns
//            their presses into registered restart / pause / goto_third
//            controls, holding a goto request until the sequencer is terminal.
// Revision : 1.0 - initial release
// ============================================================================
module seq_ctrl_cond #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_restart_n,
    input  logic btn_pause_n,
    input  logic btn_goto_n,
    input  logic terminal_in,
    output logic restart,
    output logic pause,
    output logic goto_third,
    output logic goto_pending
);

    // Counter only has to reach DEBOUNCE_CYCLES-1.
    localparam int C_CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int C_NBTN    = 3;
    localparam int C_RESTART = 0;
    localparam int C_PAUSE   = 1;
    localparam int C_GOTO    = 2;

    logic [C_NBTN-1:0] w_raw_n;
    logic [C_NBTN-1:0] w_press;
    logic              w_goto_req;

    logic r_restart;
    logic r_pause;
    logic r_goto_third;
    logic r_goto_pending;

    assign w_raw_n = {btn_goto_n, btn_pause_n, btn_restart_n};

    generate
        for (genvar gi = 0; gi < C_NBTN; gi++) begin : g_btn
            logic               r_s1;
            logic               r_s2;
            logic               r_deb;
            logic [C_CNT_W-1:0] r_cnt;

            // Two-flop synchroniser; both stages reset to the released level.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_s1 <= 1'b1;
                    r_s2 <= 1'b1;
                end else begin
                    r_s1 <= w_raw_n[gi];
                    r_s2 <= r_s1;
                end
            end

            // Debounce: accept a new level only after an uninterrupted run of
            // DEBOUNCE_CYCLES differing samples; any agreement restarts the run.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_deb <= 1'b1;
                    r_cnt <= '0;
                end else if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == C_CNT_LAST) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // A press is the cycle in which deb is about to flip 1->0, so the
            // control flops below react on the same edge as the flip.
            assign w_press[gi] = r_deb & ~r_s2 & (r_cnt == C_CNT_LAST);
        end
    endgenerate

    // A goto either arrives now or is already waiting; one slot only.
    assign w_goto_req = w_press[C_GOTO] | r_goto_pending;

    // Control outputs; restart overrides and discards pause/goto activity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_restart      <= 1'b0;
            r_pause        <= 1'b0;
            r_goto_third   <= 1'b0;
            r_goto_pending <= 1'b0;
        end else if (w_press[C_RESTART]) begin
            r_restart      <= 1'b1;
            r_pause        <= 1'b0;
            r_goto_third   <= 1'b0;
            r_goto_pending <= 1'b0;
        end else begin
            r_restart      <= 1'b0;
            if (w_press[C_PAUSE]) begin
                r_pause <= ~r_pause;
            end
            r_goto_third   <= w_goto_req & terminal_in;
            r_goto_pending <= w_goto_req & ~terminal_in;
        end
    end

    assign restart      = r_restart;
    assign pause        = r_pause;
    assign goto_third   = r_goto_third;
    assign goto_pending = r_goto_pending;

endmodule
`default_nettype wire

// File: tb/tb_seq_ctrl_cond.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_ctrl_cond
// Brief    : Directed self-checking bench for seq_ctrl_cond (DEBOUNCE_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl_cond;

    localparam int C_DEB = 4;

    logic clk;
    logic reset_n;
    logic btn_restart_n;
    logic btn_pause_n;
    logic btn_goto_n;
    logic terminal_in;
    logic restart;
    logic pause;
    logic goto_third;
    logic goto_pending;

    int n_vec = 0;
    int n_mis = 0;

    seq_ctrl_cond #(
        .DEBOUNCE_CYCLES(C_DEB)
    ) u_dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .btn_restart_n (btn_restart_n),
        .btn_pause_n   (btn_pause_n),
        .btn_goto_n    (btn_goto_n),
        .terminal_in   (terminal_in),
        .restart       (restart),
        .pause         (pause),
        .goto_third    (goto_third),
        .goto_pending  (goto_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic p,
                           input logic g, input logic gp);
        chk({tag, ".restart"},      restart,      r);
        chk({tag, ".pause"},        pause,        p);
        chk({tag, ".goto_third"},   goto_third,   g);
        chk({tag, ".goto_pending"}, goto_pending, gp);
    endtask

    initial begin
        logic [7:0] bounce;

        btn_restart_n = 1'b1;
        btn_pause_n   = 1'b1;
        btn_goto_n    = 1'b1;
        terminal_in   = 1'b0;
        reset_n       = 1'b1;
        #1 reset_n    = 1'b0;
        #1;
        chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        reset_n = 1'b1;
        tick(3);
        chk_all("idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Held restart: one pulse registered on edge 5 only.
        btn_restart_n = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk($sformatf("rst_hold_e%0d", k), restart, (k == C_DEB + 1));
        end
        btn_restart_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            chk($sformatf("rst_rel_e%0d", k), restart, 1'b0);
        end

        // Bouncy pause: L L L H L L L H (MSB first), then a clean low run.
        bounce = 8'b0001_0001;
        for (int i = 7; i >= 0; i--) begin
            btn_pause_n = bounce[i];
            tick(1);
            chk($sformatf("bounce_%0d", i), pause, 1'b0);
        end
        btn_pause_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick(1);
            chk($sformatf("pause_on_e%0d", k), pause, (k >= C_DEB + 1));
        end
        tick(3);
        chk("pause_held", pause, 1'b1);
        btn_pause_n = 1'b1;
        tick(10);
        chk("pause_release", pause, 1'b1);
        btn_pause_n = 1'b0;
        tick(5);
        chk("pause_off_pre", pause, 1'b1);
        tick(1);
        chk("pause_off", pause, 1'b0);
        btn_pause_n = 1'b1;
        tick(10);

        // Set pause, then restart and pause flipping on the same edge.
        btn_pause_n = 1'b0;
        tick(6);
        chk("pause_set", pause, 1'b1);
        btn_pause_n = 1'b1;
        tick(10);
        btn_restart_n = 1'b0;
        btn_pause_n   = 1'b0;
        tick(5);
        chk_all("dual_pre", 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        chk_all("dual_hit", 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("dual_post", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_restart_n = 1'b1;
        btn_pause_n   = 1'b1;
        tick(10);
        chk("dual_settle", pause, 1'b0);

        // Goto while not terminal goes pending, fires when terminal arrives.
        btn_goto_n = 1'b0;
        tick(5);
        chk("goto_pre", goto_pending, 1'b0);
        tick(1);
        chk_all("goto_pend", 1'b0, 1'b0, 1'b0, 1'b1);
        btn_goto_n = 1'b1;
        tick(10);
        chk_all("goto_wait", 1'b0, 1'b0, 1'b0, 1'b1);
        terminal_in = 1'b1;
        tick(1);
        chk_all("goto_fire", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_all("goto_once", 1'b0, 1'b0, 1'b0, 1'b0);
        terminal_in = 1'b0;
        tick(2);

        // Pending goto cancelled by restart before terminal.
        btn_goto_n = 1'b0;
        tick(6);
        chk("cancel_pend", goto_pending, 1'b1);
        btn_goto_n = 1'b1;
        tick(10);
        btn_restart_n = 1'b0;
        tick(6);
        chk_all("cancel_rst", 1'b1, 1'b0, 1'b0, 1'b0);
        btn_restart_n = 1'b1;
        tick(10);
        terminal_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk($sformatf("cancel_term_%0d", k), goto_third, 1'b0);
        end
        terminal_in = 1'b0;
        tick(2);

        // Reset mid-count with goto held and pause set.
        btn_pause_n = 1'b0;
        tick(6);
        chk("pre_rst_pause", pause, 1'b1);
        btn_pause_n = 1'b1;
        tick(10);
        btn_goto_n = 1'b0;
        tick(3);
        #2 reset_n = 1'b0;
        #1;
        chk_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        chk_all("in_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        terminal_in = 1'b1;
        reset_n     = 1'b1;
        tick(5);
        chk_all("post_rst_pre", 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_all("post_rst_fire", 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        chk_all("post_rst_once", 1'b0, 1'b0, 1'b0, 1'b0);
        btn_goto_n  = 1'b1;
        terminal_in = 1'b0;
        tick(10);
        chk_all("final", 1'b0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
